alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational 8-bit ALU between two requesters, e.g. the CPU execute stage (port 0) and a debug/DMA-style secondary master (port 1).
- Each request uses a REQ/ACK handshake. A round-robin arbiter grants one requester at a time.
- The block drives the ALU inputs from registers, waits a programmable settle time, then captures RESULT into a register and returns it with a one-cycle ACK.
- It sits between the requesters and the existing ALU instance; it does not contain the ALU.

Parameters:
- WIDTH, 8, operand/result width.
- SEL_W, 3, ALU SELECT width.
- EXEC_CYCLES, 2, cycles the ALU inputs are held before RESULT is sampled (range 1..15; covers the ALU's simulation delays).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ0  in  1  request from requester 0; held until ACK0.
- DATA1_0  in  WIDTH  operand 1 from requester 0.
- DATA2_0  in  WIDTH  operand 2 from requester 0.
- SELECT_0  in  SEL_W  opcode from requester 0.
- REQ1, DATA1_1, DATA2_1, SELECT_1  in  1/WIDTH/WIDTH/SEL_W  same fields for requester 1.
- ALU_DATA1  out  WIDTH  registered drive to ALU DATA1.
- ALU_DATA2  out  WIDTH  registered drive to ALU DATA2.
- ALU_SELECT  out  SEL_W  registered drive to ALU SELECT.
- ALU_RESULT  in  WIDTH  from ALU RESULT.
- RESULT  out  WIDTH  registered result, valid while ACK0|ACK1.
- ACK0  out  1  one-cycle completion pulse for requester 0.
- ACK1  out  1  one-cycle completion pulse for requester 1.
- ERR  out  1  high with ACK when the opcode was illegal.
- BUSY  out  1  high when state != IDLE.
- GRANT_ID  out  1  requester currently owning the ALU; last owner while idle.

Behaviour:
- Reset: state=IDLE; PRIO=0; GRANT_ID=0; ALU_DATA1/ALU_DATA2/ALU_SELECT=0; RESULT=0; ACK0/ACK1/ERR=0; BUSY=0.
- Reset wins over every other event, including mid-EXEC and during an ACK cycle; any in-flight operation is dropped without ACK.
- Opcodes (ALU set): 000 FORWARD (DATA2), 001 ADD, 010 AND, 011 OR. SELECT[2]=1 is illegal.
- State machine has three states: IDLE, EXEC, RESP.
- IDLE arbitration:
  - Only REQ0 high: grant 0. Only REQ1 high: grant 1.
  - Both high: grant PRIO, then PRIO <= ~granted.
  - A single grant also sets PRIO <= ~granted.
  - On grant, latch that requester's DATA1/DATA2/SELECT into the ALU_* registers, set GRANT_ID, load the counter with EXEC_CYCLES-1, and go to EXEC.
- IDLE with an illegal opcode: ALU_* registers stay unchanged. Next state is RESP with RESULT=0x00 and ERR=1; PRIO still rotates.
- EXEC:
  - Decrement the counter each cycle; ALU_* registers stay stable.
  - When the counter is 0: RESULT <= ALU_RESULT, ACK[GRANT_ID] <= 1, ERR <= 0, go to RESP.
- RESP:
  - The ACK pulse is high for exactly this one cycle; RESULT is valid.
  - REQ inputs are ignored. At the edge, ACK clears and state returns to IDLE.
  - RESULT holds its value until the next capture.
- Latency: REQ sampled at edge N (legal opcode) → ACK high in the cycle after edge N+EXEC_CYCLES.
  - EXEC_CYCLES=2: ACK is visible 3 cycles after REQ is raised.
  - Illegal opcode: ACK after 1 edge.
- Requester rules:
  - Operands must stay stable while REQ is high until ACK.
  - The requester deasserts REQ at the edge ending its ACK cycle.
  - REQ still high in the next IDLE cycle counts as a new request; round-robin ensures the other requester is served first if it is waiting.
- Changes to requester operands after the grant have no effect (they are latched).
- ACK0 and ACK1 are never high together.
- Arithmetic: ADD wraps modulo 2^WIDTH with no carry out. The arbiter passes the result through unmodified.

Decomposition:
- Shared package alu_defs:
  - Opcode constants OP_FWD=3'b000, OP_ADD=3'b001, OP_AND=3'b010, OP_OR=3'b011.
  - Legality check on SELECT[2].
  - State encodings S_IDLE/S_EXEC/S_RESP.
- One sub-module is natural: rr_arb2, a 2-way round-robin grant from (REQ0, REQ1, PRIO) to (grant_valid, grant_id, next_prio), purely combinational.
- FSM, counter and registers stay in alu_arbiter.
- The bench instantiates the existing ALU and connects it to the ALU_* ports.

Test Plan:
- Reset, then REQ0=1, DATA1_0=0xAA, DATA2_0=0x55, SELECT_0=001 → ALU_SELECT=001 after 1 edge; ACK0 pulses 1 cycle with RESULT=0xFF, ERR=0; ACK1 stays 0.
- REQ0 and REQ1 raised on the same edge:
  - REQ0 carries 0xF0 AND 0x0F (010); REQ1 carries 0xF0 OR 0x0F (011).
  - Required: ACK0 first with RESULT=0x00, then ACK1 with RESULT=0xFF; PRIO=0 after both.
- Both REQ held high for 4 transactions → grant order 0,1,0,1; RESULT unchanged between ACKs.
- Wrap and forward:
  - REQ1 with 0xC8+0x64 ADD → RESULT=0x2C.
  - Then REQ1 with SELECT=000, DATA2=0x3C → RESULT=0x3C.
- REQ0 with SELECT=101 → ACK0 one edge after sampling, ERR=1, RESULT=0x00; ALU_* registers unchanged.
- RESET asserted mid-EXEC → next cycle BUSY=0, no ACK, all outputs at reset values. A subsequent REQ1 with 0x01+0x01 ADD returns 0x02.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared opcodes, FSM states and opcode legality for the ALU arbiter
package alu_defs;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // The ALU only implements the lower half of the opcode space.
  function automatic logic op_legal(input logic [2:0] sel);
    return ~sel[2];
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester and ALU-side signal bundle for the ALU arbiter
interface alu_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
);
  logic             req0;
  logic [WIDTH-1:0] data1_0;
  logic [WIDTH-1:0] data2_0;
  logic [SEL_W-1:0] select_0;
  logic             req1;
  logic [WIDTH-1:0] data1_1;
  logic [WIDTH-1:0] data2_1;
  logic [SEL_W-1:0] select_1;
  logic [WIDTH-1:0] alu_data1;
  logic [WIDTH-1:0] alu_data2;
  logic [SEL_W-1:0] alu_select;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] result;
  logic             ack0;
  logic             ack1;
  logic             err;
  logic             busy;
  logic             grant_id;

  modport master (
    output req0, data1_0, data2_0, select_0,
    output req1, data1_1, data2_1, select_1,
    output alu_result,
    input  alu_data1, alu_data2, alu_select,
    input  result, ack0, ack1, err, busy, grant_id
  );

  modport slave (
    input  req0, data1_0, data2_0, select_0,
    input  req1, data1_1, data2_1, select_1,
    input  alu_result,
    output alu_data1, alu_data2, alu_select,
    output result, ack0, ack1, err, busy, grant_id
  );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// rtl/alu_arbiter_rr_arb2.sv - combinational two-way round-robin grant
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic grant_valid,
  output logic grant_id,
  output logic next_prio
);
  assign grant_valid = req0 | req1;
  // With both requesting, prio picks the winner; otherwise the lone requester wins.
  assign grant_id    = (req0 & req1) ? prio : req1;
  assign next_prio   = ~grant_id;
endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between two requesters via REQ/ACK
module alu_arbiter
  import alu_defs::*;
#(
  parameter int WIDTH       = 8,
  parameter int SEL_W       = 3,
  parameter int EXEC_CYCLES = 2
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  state_t           state;
  logic             prio;
  logic [3:0]       cnt;
  logic             gnt_valid;
  logic             gnt_id;
  logic             gnt_next_prio;
  logic [WIDTH-1:0] gnt_d1;
  logic [WIDTH-1:0] gnt_d2;
  logic [SEL_W-1:0] gnt_sel;

  rr_arb2 u_rr (
    .req0        (bus.req0),
    .req1        (bus.req1),
    .prio        (prio),
    .grant_valid (gnt_valid),
    .grant_id    (gnt_id),
    .next_prio   (gnt_next_prio)
  );

  assign gnt_d1   = gnt_id ? bus.data1_1  : bus.data1_0;
  assign gnt_d2   = gnt_id ? bus.data2_1  : bus.data2_0;
  assign gnt_sel  = gnt_id ? bus.select_1 : bus.select_0;
  assign bus.busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      prio           <= 1'b0;
      cnt            <= '0;
      bus.grant_id   <= 1'b0;
      bus.alu_data1  <= '0;
      bus.alu_data2  <= '0;
      bus.alu_select <= '0;
      bus.result     <= '0;
      bus.ack0       <= 1'b0;
      bus.ack1       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_valid) begin
            prio         <= gnt_next_prio;
            bus.grant_id <= gnt_id;
            if (op_legal(gnt_sel)) begin
              bus.alu_data1  <= gnt_d1;
              bus.alu_data2  <= gnt_d2;
              bus.alu_select <= gnt_sel;
              cnt            <= 4'(EXEC_CYCLES - 1);
              state          <= S_EXEC;
            end else begin
              // Illegal opcode never reaches the ALU; answer immediately with ERR.
              bus.result <= '0;
              bus.err    <= 1'b1;
              bus.ack0   <= ~gnt_id;
              bus.ack1   <= gnt_id;
              state      <= S_RESP;
            end
          end
        end
        S_EXEC: begin
          if (cnt == 4'd0) begin
            bus.result <= bus.alu_result;
            bus.err    <= 1'b0;
            bus.ack0   <= ~bus.grant_id;
            bus.ack1   <= bus.grant_id;
            state      <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          bus.err  <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for the ALU arbiter with a behavioural ALU
module tb_alu_arbiter;

  typedef struct packed {
    logic       port;
    logic [7:0] res;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  logic [7:0] last_res = 8'h00;

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(8), .SEL_W(3)) bus ();

  alu_arbiter #(.WIDTH(8), .SEL_W(3), .EXEC_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Stand-in for the existing ALU instance.
  always_comb begin
    case (bus.alu_select)
      3'b000:  bus.alu_result = bus.alu_data2;
      3'b001:  bus.alu_result = bus.alu_data1 + bus.alu_data2;
      3'b010:  bus.alu_result = bus.alu_data1 & bus.alu_data2;
      3'b011:  bus.alu_result = bus.alu_data1 | bus.alu_data2;
      default: bus.alu_result = 8'h00;
    endcase
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_res = 8'h00;
      end else if (bus.ack0 || bus.ack1) begin
        check("ack_exclusive", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_ack", {31'd0, bus.ack1}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("ack_port", {31'd0, bus.ack1}, {31'd0, e.port});
          check("result", {24'd0, bus.result}, {24'd0, e.res});
          check("err", {31'd0, bus.err}, {31'd0, e.err});
          last_res = e.res;
        end
      end else begin
        check("idle_hold", {23'd0, bus.err, bus.result}, {24'd0, last_res});
      end
    end
  endtask

  task automatic drive(input logic p, input logic r, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [2:0] sel);
    if (p) begin
      bus.req1 = r; bus.data1_1 = d1; bus.data2_1 = d2; bus.select_1 = sel;
    end else begin
      bus.req0 = r; bus.data1_0 = d1; bus.data2_0 = d2; bus.select_0 = sel;
    end
  endtask

  task automatic run_req(input logic p, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [2:0] sel, output int lat);
    lat = -1;
    @(posedge clk); #1;
    drive(p, 1'b1, d1, d2, sel);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (p ? bus.ack1 : bus.ack0) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: port %0d got no ack, want ack within 40 cycles", p);
    end
    @(posedge clk); #1;
    drive(p, 1'b0, 8'h00, 8'h00, 3'b000);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 3'b000);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 3'b000);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int lat0;
    int lat1;
    int acks;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 3'b000);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 3'b000);
    fork monitor(); join_none
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_acks", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_result", {24'd0, bus.result}, 32'd0);
    check("rst_alu_regs", {13'd0, bus.alu_select, bus.alu_data2, bus.alu_data1}, 32'd0);
    check("rst_grant_id", {31'd0, bus.grant_id}, 32'd0);

    // Single ADD from port 0; ALU_SELECT is driven one edge after sampling.
    sb.push_back('{1'b0, 8'hFF, 1'b0});
    fork
      run_req(1'b0, 8'hAA, 8'h55, 3'b001, lat0);
      begin
        @(posedge clk); @(posedge clk); #2;
        check("alu_select_latched", {29'd0, bus.alu_select}, 32'd1);
        check("busy_exec", {31'd0, bus.busy}, 32'd1);
      end
    join
    check("latency_legal", lat0, 32'd3);

    // Simultaneous requests from a fresh reset: port 0 first, then port 1.
    do_reset();
    sb.push_back('{1'b0, 8'h00, 1'b0});
    sb.push_back('{1'b1, 8'hFF, 1'b0});
    fork
      run_req(1'b0, 8'hF0, 8'h0F, 3'b010, lat0);
      run_req(1'b1, 8'hF0, 8'h0F, 3'b011, lat1);
    join
    check("grant_id_last_owner", {31'd0, bus.grant_id}, 32'd1);

    // Both held for four transactions: strict alternation starting at port 0.
    sb.push_back('{1'b0, 8'h30, 1'b0});
    sb.push_back('{1'b1, 8'h3F, 1'b0});
    sb.push_back('{1'b0, 8'h30, 1'b0});
    sb.push_back('{1'b1, 8'h3F, 1'b0});
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 8'hF0, 8'h3C, 3'b010);
    drive(1'b1, 1'b1, 8'h0F, 8'h30, 3'b011);
    acks = 0;
    for (int k = 0; k < 60 && acks < 4; k++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) acks++;
    end
    check("rr_ack_count", acks, 32'd4);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 3'b000);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 3'b000);

    // Wrapping ADD and FORWARD on port 1.
    sb.push_back('{1'b1, 8'h2C, 1'b0});
    run_req(1'b1, 8'hC8, 8'h64, 3'b001, lat1);
    check("latency_port1", lat1, 32'd3);
    sb.push_back('{1'b1, 8'h3C, 1'b0});
    run_req(1'b1, 8'h11, 8'h3C, 3'b000, lat1);

    // Illegal opcode: immediate error response, ALU drive untouched.
    sb.push_back('{1'b0, 8'h00, 1'b1});
    run_req(1'b0, 8'h77, 8'h88, 3'b101, lat0);
    check("latency_illegal", lat0, 32'd1);
    check("alu_regs_kept", {13'd0, bus.alu_select, bus.alu_data2, bus.alu_data1}, 32'h0000_3C11);

    // Reset during EXEC drops the operation without an ACK.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 8'h05, 8'h06, 3'b001);
    @(posedge clk); #1;
    check("busy_before_reset", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_busy", {31'd0, bus.busy}, 32'd0);
    check("midreset_acks", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    check("midreset_result", {23'd0, bus.err, bus.result}, 32'd0);
    check("midreset_alu_regs", {13'd0, bus.alu_select, bus.alu_data2, bus.alu_data1}, 32'd0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 3'b000);

    sb.push_back('{1'b1, 8'h02, 1'b0});
    run_req(1'b1, 8'h01, 8'h01, 3'b001, lat1);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
